// File: rtl/alu_rs_scheduler.sv
// Reservation station for one single-cycle-handshake ALU: buffers dispatched ops,
// wakes pending operands from the CDB, issues ready ops round-robin, returns results.
module alu_rs_scheduler #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [3:0]       disp_ctrl,
    input  logic [31:0]      disp_a,
    input  logic [31:0]      disp_b,
    input  logic [TAG_W-1:0] disp_qa,
    input  logic [TAG_W-1:0] disp_qb,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             fu_en,
    output logic [3:0]       fu_ctrl,
    output logic [31:0]      fu_a,
    output logic [31:0]      fu_b,
    input  logic [31:0]      fu_res,
    input  logic             fu_overflow,
    input  logic             fu_finish,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAG_W-1:0] res_tag,
    output logic [31:0]      res_data,
    output logic             res_overflow
);

    localparam int unsigned PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [TAG_W-1:0]   issue_tag;

    logic [ENTRIES-1:0] ent_valid;
    logic [3:0]         ent_ctrl [ENTRIES];
    logic [31:0]        ent_va   [ENTRIES];
    logic [31:0]        ent_vb   [ENTRIES];
    logic [TAG_W-1:0]   ent_qa   [ENTRIES];
    logic [TAG_W-1:0]   ent_qb   [ENTRIES];
    logic [TAG_W-1:0]   ent_tag  [ENTRIES];

    logic [ENTRIES-1:0] ent_ready;
    logic               free_found;
    logic [PTR_W-1:0]   free_idx;
    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic               disp_hit_a;
    logic               disp_hit_b;

    function automatic logic [PTR_W-1:0] wrap_idx(input int unsigned v);
        return PTR_W'((v >= ENTRIES) ? v - ENTRIES : v);
    endfunction

    always_comb begin
        ent_ready = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            ent_ready[i] = ent_valid[i] && (ent_qa[i] == '0) && (ent_qb[i] == '0);
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!ent_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = PTR_W'(i);
            end
        end
    end

    // Search starts at the round-robin pointer and wraps once around the station.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned off = 0; off < ENTRIES; off++) begin
            if (!sel_found && ent_ready[wrap_idx(32'(ptr) + off)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_idx(32'(ptr) + off);
            end
        end
    end

    assign disp_ready = free_found;
    assign disp_hit_a = cdb_valid && (disp_qa != '0) && (disp_qa == cdb_tag);
    assign disp_hit_b = cdb_valid && (disp_qb != '0) && (disp_qb == cdb_tag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            issue_tag    <= '0;
            ent_valid    <= '0;
            fu_en        <= 1'b0;
            fu_ctrl      <= '0;
            fu_a         <= '0;
            fu_b         <= '0;
            res_valid    <= 1'b0;
            res_tag      <= '0;
            res_data     <= '0;
            res_overflow <= 1'b0;
        end else begin
            if (cdb_valid) begin
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    if (ent_valid[i] && (ent_qa[i] != '0) && (ent_qa[i] == cdb_tag)) begin
                        ent_va[i] <= cdb_data;
                        ent_qa[i] <= '0;
                    end
                    if (ent_valid[i] && (ent_qb[i] != '0) && (ent_qb[i] == cdb_tag)) begin
                        ent_vb[i] <= cdb_data;
                        ent_qb[i] <= '0;
                    end
                end
            end

            // The free slot is invalid, so it never collides with the wakeup or issue writes.
            if (disp_valid && free_found) begin
                ent_valid[free_idx] <= 1'b1;
                ent_ctrl[free_idx]  <= disp_ctrl;
                ent_tag[free_idx]   <= disp_tag;
                ent_va[free_idx]    <= disp_hit_a ? cdb_data : disp_a;
                ent_qa[free_idx]    <= disp_hit_a ? '0 : disp_qa;
                ent_vb[free_idx]    <= disp_hit_b ? cdb_data : disp_b;
                ent_qb[free_idx]    <= disp_hit_b ? '0 : disp_qb;
            end

            case (state)
                IDLE: begin
                    if (sel_found) begin
                        fu_ctrl            <= ent_ctrl[sel_idx];
                        fu_a               <= ent_va[sel_idx];
                        fu_b               <= ent_vb[sel_idx];
                        issue_tag          <= ent_tag[sel_idx];
                        ent_valid[sel_idx] <= 1'b0;
                        ptr                <= wrap_idx(32'(sel_idx) + 1);
                        fu_en              <= 1'b1;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    fu_en <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (fu_finish) begin
                        res_data     <= fu_res;
                        res_overflow <= fu_overflow;
                        res_tag      <= issue_tag;
                        res_valid    <= 1'b1;
                        state        <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench for alu_rs_scheduler: directed dispatches push expected results,
// a monitor pops and compares on every accepted result; a small ALU model answers fu_en.
module tb_alu_rs_scheduler;

    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] SUB = 4'b0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  disp_ctrl;
    logic [31:0] disp_a, disp_b;
    logic [3:0]  disp_qa, disp_qb, disp_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        fu_en;
    logic [3:0]  fu_ctrl;
    logic [31:0] fu_a, fu_b;
    logic [31:0] fu_res;
    logic        fu_overflow;
    logic        fu_finish;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_tag;
    logic [31:0] res_data;
    logic        res_overflow;

    logic alu_auto  = 1'b1;
    logic force_fin = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        logic        ovf;
    } exp_t;
    exp_t sb[$];

    alu_rs_scheduler #(.ENTRIES(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ctrl(disp_ctrl),
        .disp_a(disp_a), .disp_b(disp_b), .disp_qa(disp_qa), .disp_qb(disp_qb),
        .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_en(fu_en), .fu_ctrl(fu_ctrl), .fu_a(fu_a), .fu_b(fu_b),
        .fu_res(fu_res), .fu_overflow(fu_overflow), .fu_finish(fu_finish),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
        .res_data(res_data), .res_overflow(res_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] tag, input logic [31:0] data, input logic ovf);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    task automatic dispatch(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] qa, input logic [3:0] qb, input logic [3:0] tag,
                            input logic cv, input logic [3:0] ct, input logic [31:0] cd);
        tick();
        disp_valid = 1'b1;
        disp_ctrl  = c;
        disp_a     = a;
        disp_b     = b;
        disp_qa    = qa;
        disp_qb    = qb;
        disp_tag   = tag;
        cdb_valid  = cv;
        cdb_tag    = ct;
        cdb_data   = cd;
        tick();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
    endtask

    task automatic cdb_pulse(input logic [3:0] tag, input logic [31:0] data);
        tick();
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic wait_res_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !res_valid;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // Single-cycle ALU: finish one cycle after the EN pulse
    initial begin
        logic        en_s;
        logic [3:0]  mc;
        logic [31:0] ma, mb, r;
        fu_finish   = 1'b0;
        fu_res      = '0;
        fu_overflow = 1'b0;
        forever begin
            @(negedge clk);
            en_s = fu_en;
            mc   = fu_ctrl;
            ma   = fu_a;
            mb   = fu_b;
            @(posedge clk);
            #1;
            if (force_fin) begin
                fu_finish   = 1'b1;
                fu_res      = 32'h1234_5678;
                fu_overflow = 1'b1;
            end else if (en_s && alu_auto) begin
                r           = (mc == SUB) ? ma - mb : ma + mb;
                fu_finish   = 1'b1;
                fu_res      = r;
                fu_overflow = (mc == SUB) ? ((ma[31] != mb[31]) && (r[31] != ma[31]))
                                          : ((ma[31] == mb[31]) && (r[31] != ma[31]));
            end else begin
                fu_finish = 1'b0;
            end
        end
    end

    // Monitor: every accepted result must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got tag 0x%0h data 0x%0h required none", res_tag, res_data);
                end else begin
                    e = sb.pop_front();
                    chk("res_tag", 32'(res_tag), 32'(e.tag));
                    chk("res_data", res_data, e.data);
                    chk("res_overflow", 32'(res_overflow), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        disp_valid = 1'b0;
        disp_ctrl  = '0;
        disp_a     = '0;
        disp_b     = '0;
        disp_qa    = '0;
        disp_qb    = '0;
        disp_tag   = '0;
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_data   = '0;
        res_ready  = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_fu_en", 32'(fu_en), 0);
        chk("rst_disp_ready", 32'(disp_ready), 1);
        chk("rst_res_data", res_data, 0);

        // ADD 5+7, latency check
        push(4'd3, 32'd12, 1'b0);
        dispatch(ADD, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3, 1'b0, 4'd0, 32'd0);
        @(negedge clk); chk("lat_en_d1", 32'(fu_en), 0);
        @(negedge clk); chk("lat_en_d2", 32'(fu_en), 1);
        @(negedge clk); chk("lat_en_d3", 32'(fu_en), 0);
                        chk("lat_valid_d3", 32'(res_valid), 0);
        @(negedge clk); chk("lat_valid_d4", 32'(res_valid), 1);
        wait_drain("drain_add");

        // Overflow result held under backpressure
        tick();
        res_ready = 1'b0;
        push(4'd2, 32'h8000_0000, 1'b1);
        dispatch(ADD, 32'h7FFF_FFFF, 32'd1, 4'd0, 4'd0, 4'd2, 1'b0, 4'd0, 32'd0);
        wait_res_valid("ovf_res_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_data", res_data, 32'h8000_0000);
            chk("hold_ovf", 32'(res_overflow), 1);
            chk("hold_tag", 32'(res_tag), 2);
        end
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_idle", 32'(res_valid), 0);
        wait_drain("drain_ovf");

        // SUB with A pending, woken two cycles after dispatch
        push(4'd6, 32'd7, 1'b0);
        dispatch(SUB, 32'hDEAD, 32'd3, 4'd5, 4'd0, 4'd6, 1'b0, 4'd0, 32'd0);
        @(negedge clk); chk("pend_en_d1", 32'(fu_en), 0);
        tick();
        cdb_valid = 1'b1;
        cdb_tag   = 4'd5;
        cdb_data  = 32'd10;
        @(negedge clk); chk("pend_en_d2", 32'(fu_en), 0);
        tick();
        cdb_valid = 1'b0;
        @(negedge clk); chk("pend_en_d3", 32'(fu_en), 0);
        @(negedge clk); chk("pend_en_d4", 32'(fu_en), 1);
        wait_drain("drain_sub_late");

        // Same-cycle CDB on A, then on B
        push(4'd7, 32'd7, 1'b0);
        dispatch(SUB, 32'hDEAD, 32'd3, 4'd5, 4'd0, 4'd7, 1'b1, 4'd5, 32'd10);
        wait_drain("drain_sub_same_a");
        push(4'd8, 32'd21, 1'b0);
        dispatch(ADD, 32'd1, 32'hBEEF, 4'd0, 4'd8, 4'd8, 1'b1, 4'd8, 32'd20);
        wait_drain("drain_add_same_b");

        // Reset clears outputs and pointer
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_res_data", res_data, 0);
        chk("rst2_res_tag", 32'(res_tag), 0);
        chk("rst2_fu_a", fu_a, 0);

        // Fill station with pending ops, 5th dispatch ignored, single wakeup
        for (int k = 0; k < 4; k++) begin
            push(4'(10 + k), 32'(100 * (k + 1) + 1), 1'b0);
            dispatch(ADD, 32'hFFFF_FFFF, 32'(100 * (k + 1)), 4'd9, 4'd0, 4'(10 + k),
                     1'b0, 4'd0, 32'd0);
        end
        @(negedge clk); chk("full_disp_ready", 32'(disp_ready), 0);
        dispatch(ADD, 32'd5, 32'd5, 4'd0, 4'd0, 4'd15, 1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_no_issue", 32'(fu_en), 0);
        end
        cdb_pulse(4'd9, 32'd1);
        wait_drain("drain_fill");

        // Pointer at 1 with entries 0 and 2 ready: entry 2 first
        tick();
        res_ready = 1'b0;
        push(4'd1, 32'd2, 1'b0);
        dispatch(ADD, 32'd1, 32'd1, 4'd0, 4'd0, 4'd1, 1'b0, 4'd0, 32'd0);
        wait_res_valid("rr_first_valid");
        push(4'd4, 32'd8, 1'b0);
        push(4'd2, 32'd4, 1'b0);
        push(4'd3, 32'd10, 1'b0);
        dispatch(ADD, 32'd2, 32'd2, 4'd0, 4'd0, 4'd2, 1'b0, 4'd0, 32'd0);
        dispatch(ADD, 32'd0, 32'd3, 4'd7, 4'd0, 4'd3, 1'b0, 4'd0, 32'd0);
        dispatch(ADD, 32'd4, 32'd4, 4'd0, 4'd0, 4'd4, 1'b0, 4'd0, 32'd0);
        tick();
        res_ready = 1'b1;
        repeat (16) @(negedge clk);
        cdb_pulse(4'd7, 32'd7);
        wait_drain("drain_rr");

        // Reset during WAIT with a full station
        alu_auto = 1'b0;
        dispatch(ADD, 32'd1, 32'd2, 4'd0, 4'd0, 4'd4, 1'b0, 4'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            dispatch(ADD, 32'd0, 32'(k), 4'd6, 4'd0, 4'(10 + k), 1'b0, 4'd0, 32'd0);
        end
        @(negedge clk);
        chk("wait_full", 32'(disp_ready), 0);
        chk("wait_no_result", 32'(res_valid), 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_res_valid", 32'(res_valid), 0);
        chk("rstw_fu_en", 32'(fu_en), 0);
        chk("rstw_disp_ready", 32'(disp_ready), 1);
        chk("rstw_fu_ctrl", 32'(fu_ctrl), 0);
        chk("rstw_fu_b", fu_b, 0);
        force_fin = 1'b1;
        @(negedge clk);
        force_fin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_finish_ignored", 32'(res_valid), 0);
        end
        cdb_pulse(4'd6, 32'd50);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("entries_cleared", 32'(fu_en), 0);
        end
        alu_auto = 1'b1;
        push(4'd5, 32'd42, 1'b0);
        dispatch(ADD, 32'd20, 32'd22, 4'd0, 4'd0, 4'd5, 1'b0, 4'd0, 32'd0);
        wait_drain("drain_after_reset");

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
